sound_reg_file: RTL and testbench

- CPU-facing register responder for the four sound channels: the writer side that produces the NR10–NR52 bytes and wave-RAM halfwords the channel blocks consume.
- Decodes 16-bit I/O bus accesses at 0x060–0x09F (low address byte), stores register state, masks readback and emits one-cycle trigger pulses.
- Sits between the I/O bus fabric and square1/square2/wave/noise plus the mixer.

---
 rtl/sound_reg_file_if.sv | 22 ++
 rtl/sound_reg_file.sv | 163 ++++++++++++++++
 tb/tb_sound_reg_file.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sound_reg_file_if.sv
// rtl/sound_reg_file_if.sv - CPU I/O bus bundle for the sound register responder
interface sound_reg_file_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wr;
    logic              bus_rd;
    logic [1:0]        bus_be;
    logic [15:0]       bus_wdata;
    logic [15:0]       bus_rdata;
    logic              bus_rvalid;

    modport master (
        output bus_addr, bus_wr, bus_rd, bus_be, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_wr, bus_rd, bus_be, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/sound_reg_file.sv
// rtl/sound_reg_file.sv - NR10-NR52 and wave RAM register responder with trigger pulses
// Optional macro SOUND_WAVE_BANK_EN: two wave RAM banks, NR30[6] picks the playing one.
module sound_reg_file #(
    parameter int ADDR_W          = 8,
    parameter bit MASTER_EN_RESET = 1'b0
) (
    input  logic               system_clock,
    input  logic               reset,
    sound_reg_file_if.slave    bus,
    input  logic [3:0]         chan_active,
    output logic [7:0]         NR10, NR11, NR12, NR13, NR14,
    output logic [7:0]         NR21, NR22, NR23, NR24,
    output logic [7:0]         NR30, NR31, NR32, NR33, NR34,
    output logic [7:0]         NR41, NR42, NR43, NR44,
    output logic [7:0]         NR50, NR51, NR52,
    output logic [15:0]        addr_0x90, addr_0x92, addr_0x94, addr_0x96,
    output logic [15:0]        addr_0x98, addr_0x9A, addr_0x9C, addr_0x9E,
    output logic [3:0]         trig
);
    localparam int NREG = 34;
`ifdef SOUND_WAVE_BANK_EN
    localparam int         WIDX_W  = 4;
    localparam logic [7:0] ST_NR30 = 8'hFF;
    localparam logic [7:0] RD_NR30 = 8'hE0;
`else
    localparam int         WIDX_W  = 3;
    localparam logic [7:0] ST_NR30 = 8'hBF;
    localparam logic [7:0] RD_NR30 = 8'hA0;
`endif
    localparam int NWAVE = 1 << WIDX_W;

    logic [7:0]        r_regs [0:NREG-1];
    logic [15:0]       r_wave [0:NWAVE-1];
    logic              r_master;
    logic [3:0]        r_trig;
    logic [15:0]       r_rdata;
    logic              r_rvalid;

    logic [6:0]        w_hw;
    logic [4:0]        w_slot;
    logic [5:0]        w_lo, w_hi;
    logic              w_in_regs, w_is_nr52, w_is_wave;
    logic              w_reg_wr, w_master_nxt;
    logic [3:0]        w_trig_nxt;
    logic [15:0]       w_rd_data;
    logic [WIDX_W-1:0] w_widx, w_pbase;
    logic              w_unused;

    // Byte offsets below are relative to 0x60; bit 0 of the bus address is ignored.
    function automatic logic [7:0] st_mask(input logic [5:0] b);
        case (b)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0C, 6'h12,
            6'h13, 6'h14, 6'h18, 6'h19, 6'h1C, 6'h20, 6'h21: st_mask = 8'hFF;
            6'h05, 6'h0D, 6'h15, 6'h1D:                       st_mask = 8'h7F;
            6'h10:                                            st_mask = ST_NR30;
            default:                                          st_mask = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rd_mask(input logic [5:0] b);
        case (b)
            6'h00, 6'h03, 6'h09, 6'h18, 6'h19, 6'h1C, 6'h20, 6'h21: rd_mask = 8'hFF;
            6'h02, 6'h08:                                         rd_mask = 8'hC0;
            6'h05, 6'h0D, 6'h15, 6'h1D:                           rd_mask = 8'h40;
            6'h13:                                                rd_mask = 8'hE0;
            6'h10:                                                rd_mask = RD_NR30;
            default:                                              rd_mask = 8'h00;
        endcase
    endfunction

    assign w_hw      = bus.bus_addr[7:1];
    assign w_unused  = ^{bus.bus_addr[0]};
    assign w_slot    = 5'(w_hw - 7'h30);
    assign w_lo      = {w_slot, 1'b0};
    assign w_hi      = {w_slot, 1'b1};
    assign w_in_regs = (w_hw >= 7'h30) && (w_hw <= 7'h40);
    assign w_is_nr52 = (w_hw == 7'h42);
    assign w_is_wave = (w_hw[6:3] == 4'h9);
    assign w_reg_wr  = bus.bus_wr && w_in_regs && r_master;
    assign w_master_nxt = (bus.bus_wr && w_is_nr52 && bus.bus_be[0]) ? bus.bus_wdata[7] : r_master;

    // The bus always sees the idle bank; the channel side sees the playing bank.
`ifdef SOUND_WAVE_BANK_EN
    assign w_widx  = {~r_regs[16][6], w_hw[2:0]};
    assign w_pbase = {r_regs[16][6], 3'b000};
`else
    assign w_widx  = w_hw[2:0];
    assign w_pbase = 3'b000;
`endif

    always_comb begin
        w_trig_nxt = 4'b0000;
        if (w_reg_wr && bus.bus_be[1] && bus.bus_wdata[15]) begin
            case (w_slot)
                5'd2:    w_trig_nxt[0] = 1'b1;
                5'd6:    w_trig_nxt[1] = 1'b1;
                5'd10:   w_trig_nxt[2] = 1'b1;
                5'd14:   w_trig_nxt[3] = 1'b1;
                default: w_trig_nxt = 4'b0000;
            endcase
        end
    end

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_in_regs)
            w_rd_data = {r_regs[w_hi] & rd_mask(w_hi), r_regs[w_lo] & rd_mask(w_lo)};
        else if (w_is_nr52)
            w_rd_data = {8'h00, r_master, 3'b000, chan_active};
        else if (w_is_wave)
            w_rd_data = r_wave[w_widx];
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NREG; b++)  r_regs[b] <= 8'h00;
            for (int i = 0; i < NWAVE; i++) r_wave[i] <= 16'h0000;
            r_master <= MASTER_EN_RESET;
            r_trig   <= 4'b0000;
            r_rdata  <= 16'h0000;
            r_rvalid <= 1'b0;
        end else begin
            r_master <= w_master_nxt;
            r_trig   <= w_trig_nxt;
            r_rvalid <= bus.bus_rd;
            r_rdata  <= bus.bus_rd ? w_rd_data : 16'h0000;
            for (int b = 0; b < NREG; b++) begin
                if (!w_master_nxt)
                    r_regs[b] <= 8'h00;
                else if (w_reg_wr && (w_slot == 5'(b / 2)) && bus.bus_be[b[0]])
                    r_regs[b] <= (b[0] ? bus.bus_wdata[15:8] : bus.bus_wdata[7:0]) & st_mask(6'(b));
            end
            if (bus.bus_wr && w_is_wave) begin
                if (bus.bus_be[0]) r_wave[w_widx][7:0]  <= bus.bus_wdata[7:0];
                if (bus.bus_be[1]) r_wave[w_widx][15:8] <= bus.bus_wdata[15:8];
            end
        end
    end

    assign NR10 = r_regs[0];  assign NR11 = r_regs[2];  assign NR12 = r_regs[3];
    assign NR13 = r_regs[4];  assign NR14 = r_regs[5];
    assign NR21 = r_regs[8];  assign NR22 = r_regs[9];  assign NR23 = r_regs[12];
    assign NR24 = r_regs[13];
    assign NR30 = r_regs[16]; assign NR31 = r_regs[18]; assign NR32 = r_regs[19];
    assign NR33 = r_regs[20]; assign NR34 = r_regs[21];
    assign NR41 = r_regs[24]; assign NR42 = r_regs[25]; assign NR43 = r_regs[28];
    assign NR44 = r_regs[29];
    assign NR50 = r_regs[32]; assign NR51 = r_regs[33];
    assign NR52 = {r_master, 3'b000, chan_active};

    assign addr_0x90 = r_wave[w_pbase + WIDX_W'(0)];
    assign addr_0x92 = r_wave[w_pbase + WIDX_W'(1)];
    assign addr_0x94 = r_wave[w_pbase + WIDX_W'(2)];
    assign addr_0x96 = r_wave[w_pbase + WIDX_W'(3)];
    assign addr_0x98 = r_wave[w_pbase + WIDX_W'(4)];
    assign addr_0x9A = r_wave[w_pbase + WIDX_W'(5)];
    assign addr_0x9C = r_wave[w_pbase + WIDX_W'(6)];
    assign addr_0x9E = r_wave[w_pbase + WIDX_W'(7)];

    assign trig           = r_trig;
    assign bus.bus_rdata  = r_rdata;
    assign bus.bus_rvalid = r_rvalid;
endmodule

// File: tb/tb_sound_reg_file.sv
// tb/tb_sound_reg_file.sv - directed self-checking bench for sound_reg_file
module tb_sound_reg_file;
    logic        system_clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  chan_active = 4'b0000;
    logic [7:0]  NR10, NR11, NR12, NR13, NR14, NR21, NR22, NR23, NR24;
    logic [7:0]  NR30, NR31, NR32, NR33, NR34, NR41, NR42, NR43, NR44;
    logic [7:0]  NR50, NR51, NR52;
    logic [15:0] addr_0x90, addr_0x92, addr_0x94, addr_0x96;
    logic [15:0] addr_0x98, addr_0x9A, addr_0x9C, addr_0x9E;
    logic [3:0]  trig;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 system_clock = ~system_clock;

    sound_reg_file_if #(.ADDR_W(8)) bus_if ();

    sound_reg_file #(.ADDR_W(8), .MASTER_EN_RESET(1'b0)) dut (
        .system_clock(system_clock), .reset(reset), .bus(bus_if), .chan_active(chan_active),
        .NR10(NR10), .NR11(NR11), .NR12(NR12), .NR13(NR13), .NR14(NR14),
        .NR21(NR21), .NR22(NR22), .NR23(NR23), .NR24(NR24),
        .NR30(NR30), .NR31(NR31), .NR32(NR32), .NR33(NR33), .NR34(NR34),
        .NR41(NR41), .NR42(NR42), .NR43(NR43), .NR44(NR44),
        .NR50(NR50), .NR51(NR51), .NR52(NR52),
        .addr_0x90(addr_0x90), .addr_0x92(addr_0x92), .addr_0x94(addr_0x94), .addr_0x96(addr_0x96),
        .addr_0x98(addr_0x98), .addr_0x9A(addr_0x9A), .addr_0x9C(addr_0x9C), .addr_0x9E(addr_0x9E),
        .trig(trig)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    // Called at a falling edge; drives one bus cycle and returns at the next falling edge.
    task automatic access(input logic wr, input logic rd, input logic [7:0] a,
                          input logic [1:0] be, input logic [15:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_wr    = wr;
        bus_if.bus_rd    = rd;
        bus_if.bus_be    = be;
        bus_if.bus_wdata = d;
        @(negedge system_clock);
        bus_if.bus_wr = 1'b0;
        bus_if.bus_rd = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
        access(1'b0, 1'b1, a, 2'b00, 16'h0000);
        check({tag, "_rvalid"}, 16'(bus_if.bus_rvalid), 16'h0001);
        check(tag, bus_if.bus_rdata, exp);
    endtask

    initial begin
        bus_if.bus_addr = 8'h00; bus_if.bus_wr = 1'b0; bus_if.bus_rd = 1'b0;
        bus_if.bus_be = 2'b00;   bus_if.bus_wdata = 16'h0000;
        repeat (2) @(negedge system_clock);
        check("rst_nr52", 16'(NR52), 16'h0000);
        check("rst_rvalid", 16'(bus_if.bus_rvalid), 16'h0000);
        check("rst_rdata", bus_if.bus_rdata, 16'h0000);
        check("rst_trig", 16'(trig), 16'h0000);
        reset = 1'b0;

        access(1'b1, 1'b0, 8'h84, 2'b01, 16'h0080);
        check("master_on_nr52", 16'(NR52), 16'h0080);
        access(1'b1, 1'b0, 8'h62, 2'b11, 16'h1234);
        check("nr11", 16'(NR11), 16'h0034);
        check("nr12", 16'(NR12), 16'h0012);
        check("rvalid_idle", 16'(bus_if.bus_rvalid), 16'h0000);
        read_check("rd_62", 8'h62, 16'h1200);

        access(1'b1, 1'b0, 8'h64, 2'b11, 16'hC7FF);
        check("nr13", 16'(NR13), 16'h00FF);
        check("nr14_bit7_clear", 16'(NR14), 16'h0047);
        check("trig_ch1", 16'(trig), 16'h0001);
        @(negedge system_clock);
        check("trig_ch1_end", 16'(trig), 16'h0000);
        read_check("rd_64", 8'h64, 16'h4000);

        access(1'b1, 1'b0, 8'h6C, 2'b10, 16'h8000);
        check("trig_b2b_ch2", 16'(trig), 16'h0002);
        access(1'b1, 1'b0, 8'h7C, 2'b10, 16'h8000);
        check("trig_b2b_ch4", 16'(trig), 16'h0008);
        check("nr24_bit7_clear", 16'(NR24), 16'h0000);
        access(1'b1, 1'b0, 8'h64, 2'b01, 16'h8000);
        check("trig_be_low_only", 16'(trig), 16'h0000);

        access(1'b1, 1'b0, 8'h68, 2'b01, 16'hAB55);
        check("nr21_be01", 16'(NR21), 16'h0055);
        check("nr22_unchanged", 16'(NR22), 16'h0000);
        read_check("rd_68", 8'h68, 16'h0040);

        access(1'b1, 1'b0, 8'h70, 2'b11, 16'h00BF);
        check("nr30", 16'(NR30), 16'h00BF);
        read_check("rd_70", 8'h70, 16'h00A0);
        access(1'b1, 1'b0, 8'h72, 2'b11, 16'hFF77);
        check("nr31", 16'(NR31), 16'h0077);
        read_check("rd_72", 8'h72, 16'hE000);

        access(1'b1, 1'b1, 8'h80, 2'b11, 16'h1234);
        check("rw_same_pre", bus_if.bus_rdata, 16'h0000);
        check("rw_same_nr50", 16'(NR50), 16'h0034);
        read_check("rd_80", 8'h80, 16'h1234);

        access(1'b1, 1'b0, 8'h66, 2'b11, 16'hFFFF);
        read_check("rd_unmapped_66", 8'h66, 16'h0000);
        read_check("rd_unmapped_a0", 8'hA0, 16'h0000);

        chan_active = 4'b1010;
        #1;
        check("nr52_active", 16'(NR52), 16'h008A);
        @(negedge system_clock);
        read_check("rd_84", 8'h84, 16'h008A);

        access(1'b1, 1'b0, 8'h84, 2'b01, 16'h0000);
        check("off_nr12", 16'(NR12), 16'h0000);
        check("off_nr14", 16'(NR14), 16'h0000);
        check("off_nr50", 16'(NR50), 16'h0000);
        check("off_nr52", 16'(NR52), 16'h000A);
        access(1'b1, 1'b0, 8'h80, 2'b11, 16'h0012);
        check("off_wr_ignored", 16'(NR50), 16'h0000);
        access(1'b1, 1'b0, 8'h62, 2'b11, 16'h8080);
        check("off_nr11_ignored", 16'(NR11), 16'h0000);
        access(1'b1, 1'b0, 8'h90, 2'b11, 16'hBEEF);
        access(1'b1, 1'b0, 8'h9E, 2'b10, 16'h55AA);
`ifdef SOUND_WAVE_BANK_EN
        check("wave_90_idle_bank", addr_0x90, 16'h0000);
        check("wave_9e_idle_bank", addr_0x9E, 16'h0000);
`else
        check("wave_90", addr_0x90, 16'hBEEF);
        check("wave_9e_be10", addr_0x9E, 16'h5500);
`endif
        read_check("rd_90", 8'h90, 16'hBEEF);

        access(1'b1, 1'b0, 8'h84, 2'b01, 16'h0080);
        access(1'b1, 1'b0, 8'h70, 2'b01, 16'h0040);
`ifdef SOUND_WAVE_BANK_EN
        check("bank_swap_90", addr_0x90, 16'hBEEF);
        check("bank_nr30", 16'(NR30), 16'h0040);
`else
        check("nobank_90", addr_0x90, 16'hBEEF);
        check("nobank_nr30", 16'(NR30), 16'h0000);
`endif

        access(1'b1, 1'b0, 8'h62, 2'b11, 16'h1234);
        access(1'b0, 1'b1, 8'h62, 2'b00, 16'h0000);
        check("pre_rst_rvalid", 16'(bus_if.bus_rvalid), 16'h0001);
        reset = 1'b1;
        #1;
        check("midrst_rvalid", 16'(bus_if.bus_rvalid), 16'h0000);
        check("midrst_rdata", bus_if.bus_rdata, 16'h0000);
        check("midrst_nr12", 16'(NR12), 16'h0000);
        check("midrst_nr52", 16'(NR52), 16'h000A);
        check("midrst_wave", addr_0x90, 16'h0000);
        @(negedge system_clock);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
